// File: rtl/if_id_buffer.sv
// Two-entry elastic buffer between fetch and decode. It splits the head
// instruction into MIPS fields and counts the cycles that decode stalls.
module if_id_buffer #(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [INSTR_W-1:0] if_pc,
  output logic               if_ready,
  input  logic               flush,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [5:0]         id_opcode,
  output logic [4:0]         id_rs,
  output logic [4:0]         id_rt,
  output logic [4:0]         id_rd,
  output logic [4:0]         id_shamt,
  output logic [5:0]         id_funct,
  output logic [15:0]        id_imm16,
  output logic [INSTR_W-1:0] id_pc_plus4,
  output logic [CNT_W-1:0]   stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [INSTR_W-1:0] instr_mem [2];
  logic [INSTR_W-1:0] pc_mem    [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] head_instr;
  logic [INSTR_W-1:0] head_pc;

  // Ready depends only on registered occupancy, so fetch never sees id_ready.
  assign if_ready = rst_n && (count != 2'd2);
  assign id_valid = (count != 2'd0);
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && id_ready && !flush;

  // An empty buffer presents all-zero fields regardless of stale storage.
  assign head_instr = id_valid ? instr_mem[rd_ptr] : '0;
  assign head_pc    = id_valid ? pc_mem[rd_ptr] + INSTR_W'(4) : '0;

  // Big-endian bit numbering: field "bits 0:5" is the top six bits.
  assign id_opcode   = head_instr[31:26];
  assign id_rs       = head_instr[25:21];
  assign id_rt       = head_instr[20:16];
  assign id_rd       = head_instr[15:11];
  assign id_shamt    = head_instr[10:6];
  assign id_funct    = head_instr[5:0];
  assign id_imm16    = head_instr[15:0];
  assign id_pc_plus4 = head_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      stall_cnt    <= '0;
      instr_mem[0] <= '0;
      instr_mem[1] <= '0;
      pc_mem[0]    <= '0;
      pc_mem[1]    <= '0;
    end else begin
      if (id_valid && !id_ready && !flush)
        stall_cnt <= sat_inc(stall_cnt);
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          instr_mem[wr_ptr] <= if_instr;
          pc_mem[wr_ptr]    <= if_pc;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop)
          rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, ordering, backpressure, flush,
// PC wrap, field extraction and stall-counter saturation (CNT_W = 4).
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [15:0] id_imm16;
  logic [31:0] id_pc_plus4;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  if_id_buffer #(.INSTR_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(if_ready), .flush(flush), .id_ready(id_ready),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct),
    .id_imm16(id_imm16), .id_pc_plus4(id_pc_plus4), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    flush = 1'b0; id_ready = 1'b0;
    step(); step();
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_opcode", 32'(id_opcode), 32'd0);
    chk("rst_pc_plus4", id_pc_plus4, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_if_ready", 32'(if_ready), 32'd1);

    // Single push, then drained by decode
    if_valid = 1'b1; if_instr = 32'h8C22000C; if_pc = 32'h00400000; id_ready = 1'b1;
    step();
    if_valid = 1'b0;
    chk("t1_id_valid", 32'(id_valid), 32'd1);
    chk("t1_opcode", 32'(id_opcode), 32'h23);
    chk("t1_rs", 32'(id_rs), 32'd1);
    chk("t1_rt", 32'(id_rt), 32'd2);
    chk("t1_rd", 32'(id_rd), 32'd0);
    chk("t1_shamt", 32'(id_shamt), 32'd0);
    chk("t1_funct", 32'(id_funct), 32'h0C);
    chk("t1_imm16", 32'(id_imm16), 32'h000C);
    chk("t1_pc_plus4", id_pc_plus4, 32'h00400004);
    step();
    chk("t1_drained", 32'(id_valid), 32'd0);
    chk("t1_stall", 32'(stall_cnt), 32'd0);

    // Fill to two entries under backpressure
    id_ready = 1'b0;
    if_valid = 1'b1; if_instr = 32'h00000001; if_pc = 32'h00000100;
    step();
    if_instr = 32'h00000002; if_pc = 32'h00000104;
    step();
    if_valid = 1'b0;
    chk("t2_full_if_ready", 32'(if_ready), 32'd0);
    chk("t2_head_funct", 32'(id_funct), 32'd1);
    chk("t2_head_pc4", id_pc_plus4, 32'h00000104);
    chk("t2_stall1", 32'(stall_cnt), 32'd1);
    step();
    chk("t2_stall2", 32'(stall_cnt), 32'd2);
    chk("t2_held_funct", 32'(id_funct), 32'd1);
    step();
    chk("t2_stall3", 32'(stall_cnt), 32'd3);
    id_ready = 1'b1;
    step();
    chk("t2_second_funct", 32'(id_funct), 32'd2);
    chk("t2_second_pc4", id_pc_plus4, 32'h00000108);
    chk("t2_if_ready_back", 32'(if_ready), 32'd1);
    chk("t2_stall_hold", 32'(stall_cnt), 32'd3);
    step();
    chk("t2_empty", 32'(id_valid), 32'd0);

    // Continuous stream with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      if_valid = 1'b1; if_instr = 32'h10 + 32'(i); if_pc = 32'h1000 + 32'(4 * i);
      step();
      chk("t3_valid", 32'(id_valid), 32'd1);
      chk("t3_funct", 32'(id_funct), 32'h10 + 32'(i));
      chk("t3_pc4", id_pc_plus4, 32'h1004 + 32'(4 * i));
      chk("t3_if_ready", 32'(if_ready), 32'd1);
    end
    if_valid = 1'b0;
    step();
    chk("t3_drained", 32'(id_valid), 32'd0);
    chk("t3_stall", 32'(stall_cnt), 32'd3);

    // Flush a full buffer while fetch offers a third instruction
    id_ready = 1'b0;
    if_valid = 1'b1; if_instr = 32'h00000011; if_pc = 32'h2000;
    step();
    if_instr = 32'h00000022; if_pc = 32'h2004;
    step();
    chk("t4_full", 32'(if_ready), 32'd0);
    chk("t4_stall_pre", 32'(stall_cnt), 32'd4);
    flush = 1'b1; if_instr = 32'h00000033; if_pc = 32'h2008;
    step();
    flush = 1'b0; if_valid = 1'b0;
    chk("t4_flushed_valid", 32'(id_valid), 32'd0);
    chk("t4_flushed_funct", 32'(id_funct), 32'd0);
    chk("t4_stall_unchanged", 32'(stall_cnt), 32'd4);
    chk("t4_if_ready", 32'(if_ready), 32'd1);
    step();
    chk("t4_nothing_appears", 32'(id_valid), 32'd0);

    // PC wrap and field extraction, held under backpressure
    if_valid = 1'b1; if_instr = 32'h1000FFFF; if_pc = 32'hFFFFFFFC;
    step();
    if_valid = 1'b0;
    chk("t5_opcode", 32'(id_opcode), 32'h04);
    chk("t5_imm16", 32'(id_imm16), 32'hFFFF);
    chk("t5_rs", 32'(id_rs), 32'd0);
    chk("t5_pc_wrap", id_pc_plus4, 32'h00000000);

    // Saturate the stall counter, then reset mid-operation
    for (int i = 0; i < 20; i++) step();
    chk("t6_stall_sat", 32'(stall_cnt), 32'd15);
    chk("t6_held_imm", 32'(id_imm16), 32'hFFFF);
    rst_n = 1'b0;
    #1;
    chk("t6_if_ready_in_rst", 32'(if_ready), 32'd0);
    step();
    chk("t6_rst_stall", 32'(stall_cnt), 32'd0);
    chk("t6_rst_valid", 32'(id_valid), 32'd0);
    chk("t6_rst_imm", 32'(id_imm16), 32'd0);
    chk("t6_rst_if_ready", 32'(if_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t6_if_ready_after", 32'(if_ready), 32'd1);
    step();
    chk("t6_valid_after", 32'(id_valid), 32'd0);
    chk("t6_stall_after", 32'(stall_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Two-entry elastic pipeline buffer between instruction fetch and decode in the CPU.
- Accepts a 32-bit instruction word and its PC from fetch over a valid/ready handshake.
- Presents the decoded MIPS fields to the decode stage; id_imm16 drives the 16-to-32 sign-extension unit.
- Supports synchronous flush for branch/jump redirect and counts decode-side stall cycles.

Parameters:
- INSTR_W, 32, instruction and PC width; only 32 is supported.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_valid  in  1  fetch presents a valid instruction.
- if_instr  in  32  instruction word; bit 0 = MSB.
- if_pc  in  32  PC of if_instr.
- if_ready  out  1  buffer can accept this cycle.
- flush  in  1  discard all buffered and incoming instructions.
- id_ready  in  1  decode accepts the head entry.
- id_valid  out  1  head entry valid.
- id_opcode  out  6  head instr bits 0:5.
- id_rs  out  5  bits 6:10.
- id_rt  out  5  bits 11:15.
- id_rd  out  5  bits 16:20.
- id_shamt  out  5  bits 21:25.
- id_funct  out  6  bits 26:31.
- id_imm16  out  16  bits 16:31; goes to the sign-extension unit.
- id_pc_plus4  out  32  head PC + 4.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Storage and pointers:
  - Storage is 2 entries of {instr, pc}, plus rd_ptr, wr_ptr (1 bit each) and count (0..2).
  - push = if_valid && if_ready && !flush.
  - pop = id_valid && id_ready && !flush.
- if_ready = rst_n && (count != 2). It is derived from registered state only, with no combinational path from id_ready.
- id_valid = (count != 0).
- Field outputs:
  - All field outputs are combinational slices of entry[rd_ptr].
  - They are all-zero when count == 0 (entry contents are don't-care, outputs are forced to 0).
- id_pc_plus4 = entry[rd_ptr].pc + 4, modulo 2^32. 0xFFFFFFFC wraps to 0x00000000; no carry out.
- Latency: an instruction pushed in cycle N is visible on id_* in cycle N+1 if the buffer was empty. There is no bypass path.
- Push only: write entry[wr_ptr], toggle wr_ptr, count+1.
- Pop only: toggle rd_ptr, count-1.
- Push and pop in the same cycle (count 1): count stays 1, both pointers toggle, and the new instruction becomes the head next cycle. This is legal at count 1 only. At count 2 if_ready is 0, so a push cannot occur.
- Order is strictly FIFO. No instruction is dropped or duplicated without flush.
- Flush:
  - Next cycle: count = 0, rd_ptr = wr_ptr = 0.
  - An incoming if_valid in the flush cycle is discarded even if if_ready = 1.
  - Flush takes priority over push and pop.
  - Flush does not touch stall_cnt.
- stall_cnt:
  - Increments each cycle where id_valid && !id_ready && !flush.
  - Saturates at 2^CNT_W - 1.
  - Cleared only by reset.
- Reset:
  - When rst_n = 0 at a rising edge: count = 0, pointers = 0, stall_cnt = 0, and entry storage is cleared to 0.
  - During reset: id_valid = 0, all id_* fields = 0, if_ready = 0.
  - Reset asserted mid-transfer discards all contents, with the same result as flush plus a counter clear.
- Handshake rules:
  - Fetch must hold if_instr and if_pc stable while if_valid && !if_ready.
  - The buffer holds the id_* outputs stable while id_valid && !id_ready.

Test Plan:
- Reset then single push: deassert rst_n. Push instr 0x8C22000C at pc 0x00400000 with id_ready = 1.
  Next cycle requires: id_valid = 1, opcode 0x23, rs 1, rt 2, imm16 0x000C, pc_plus4 0x00400004. The cycle after: id_valid = 0.
- Fill and backpressure: id_ready = 0, push 0x00000001 then 0x00000002.
  Requires: if_ready = 0 after the second push and stall_cnt incrementing each cycle. Raise id_ready: outputs 0x00000001 then 0x00000002 in order, and if_ready returns to 1.
- Simultaneous push/pop at count 1: stream 8 sequential instructions with id_ready = 1 continuously.
  Requires: one output per cycle, in order, with count never exceeding 1.
- Flush with full buffer plus an incoming valid: flush = 1 at count 2 with if_valid = 1.
  Requires: id_valid = 0 next cycle, none of the three instructions ever appear, stall_cnt unchanged.
- PC wrap and field extraction: push instr 0x1000FFFF at pc 0xFFFFFFFC.
  Requires: opcode 0x04, imm16 0xFFFF, id_pc_plus4 0x00000000.
- Saturation and reset mid-operation: with CNT_W = 4, hold id_valid = 1 and id_ready = 0 for 20 cycles.
  Requires: stall_cnt = 15 held. Assert rst_n = 0 for one cycle: stall_cnt = 0, id_valid = 0, if_ready = 0 during reset and 1 after.
